// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl -- lock acquisition / supervision controller for an ADPLL.
//
// Drives the ADPLL through loop reset, coarse acquisition, fine acquisition
// and locked tracking. It watches the phase error on each reference-clock
// rising edge and faults on timeout or on a railed DCO control code.
//
// Ports:
//   fpga_clk_i      system clock, all logic on rising edge
//   reset_ni        asynchronous active-low reset
//   start_i         level request to acquire lock
//   stop_i          level request to abort and return to IDLE (highest priority)
//   ref_clk_i       reference clock, asynchronous, synchronised internally
//   error_i         signed phase error from the phase detector
//   dco_cc_i        signed DCO control code from the ADPLL
//   adpll_enable_o  ADPLL enable
//   loop_reset_o    active-high ADPLL loop reset
//   gain_sel_o      loop filter gain: 10 coarse, 01 fine, 00 tracking
//   locked_o        high in LOCKED
//   lock_lost_o     one-cycle pulse on leaving LOCKED due to bad samples
//   fault_o         high in FAULT
//   state_o         current state encoding
module adpll_lock_ctrl #(
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_CNT   = 16,
    parameter int COARSE_TOL = 16,
    parameter int UNLOCK_TOL = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int TIMEOUT    = 1024,
    parameter int RST_CYCLES = 8
) (
    input  logic              fpga_clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              ref_clk_i,
    input  logic signed [7:0] error_i,
    input  logic signed [8:0] dco_cc_i,
    output logic              adpll_enable_o,
    output logic              loop_reset_o,
    output logic [1:0]        gain_sel_o,
    output logic              locked_o,
    output logic              lock_lost_o,
    output logic              fault_o,
    output logic [2:0]        state_o
);

    localparam int COARSE_CNT = 4;
    localparam int HIT_MAX0   = (LOCK_CNT > COARSE_CNT) ? LOCK_CNT : COARSE_CNT;
    localparam int HIT_MAX    = (UNLOCK_CNT > HIT_MAX0) ? UNLOCK_CNT : HIT_MAX0;
    localparam int HIT_W      = $clog2(HIT_MAX + 1);
    localparam int TMO_W      = $clog2(TIMEOUT + 1);
    localparam int RST_W      = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOP_RST = 3'd1,
        COARSE   = 3'd2,
        FINE     = 3'd3,
        LOCKED   = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [RST_W-1:0]   rst_cnt, rst_cnt_nxt;
    logic [HIT_W-1:0]   hit_cnt, hit_cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic               lost_nxt;
    logic               ref_s1, ref_s2, ref_s3;
    logic               strobe;
    logic [7:0]         abs_err;
    logic               rail;

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            ref_s3 <= 1'b0;
        end else begin
            ref_s1 <= ref_clk_i;
            ref_s2 <= ref_s1;
            ref_s3 <= ref_s2;
        end
    end

    assign strobe = ref_s2 & ~ref_s3;

    // Two's complement negate in 8 bits maps -128 to 8'h80 = 128 unsigned.
    assign abs_err = error_i[7] ? (~error_i + 8'd1) : error_i;
    assign rail    = (dco_cc_i == 9'sh0FF) || (dco_cc_i == 9'sh100);

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        hit_cnt_nxt = hit_cnt;
        tmo_cnt_nxt = tmo_cnt;
        lost_nxt    = 1'b0;

        case (state)
            IDLE: begin
                rst_cnt_nxt = '0;
                hit_cnt_nxt = '0;
                tmo_cnt_nxt = '0;
                if (start_i) state_nxt = LOOP_RST;
            end
            LOOP_RST: begin
                if (rst_cnt >= RST_W'(RST_CYCLES - 1)) begin
                    state_nxt   = COARSE;
                    rst_cnt_nxt = '0;
                    hit_cnt_nxt = '0;
                    tmo_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end
            COARSE, FINE, LOCKED: begin
                if (strobe) begin
                    // Rail first; a tolerance-driven move out of COARSE/FINE
                    // wins over a timeout on the same strobe.
                    if (rail) begin
                        state_nxt = FAULT;
                    end else if (state == COARSE) begin
                        if (abs_err <= 8'(COARSE_TOL)) begin
                            if (hit_cnt >= HIT_W'(COARSE_CNT - 1)) begin
                                state_nxt   = FINE;
                                hit_cnt_nxt = '0;
                                tmo_cnt_nxt = '0;
                            end else begin
                                hit_cnt_nxt = hit_cnt + 1'b1;
                            end
                        end else begin
                            hit_cnt_nxt = '0;
                        end
                    end else if (state == FINE) begin
                        if (abs_err > 8'(COARSE_TOL)) begin
                            state_nxt   = COARSE;
                            hit_cnt_nxt = '0;
                            tmo_cnt_nxt = '0;
                        end else if (abs_err <= 8'(LOCK_TOL)) begin
                            if (hit_cnt >= HIT_W'(LOCK_CNT - 1)) begin
                                state_nxt   = LOCKED;
                                hit_cnt_nxt = '0;
                            end else begin
                                hit_cnt_nxt = hit_cnt + 1'b1;
                            end
                        end else begin
                            hit_cnt_nxt = '0;
                        end
                    end else begin
                        if (abs_err > 8'(UNLOCK_TOL)) begin
                            if (hit_cnt >= HIT_W'(UNLOCK_CNT - 1)) begin
                                state_nxt   = FINE;
                                lost_nxt    = 1'b1;
                                hit_cnt_nxt = '0;
                                tmo_cnt_nxt = '0;
                            end else begin
                                hit_cnt_nxt = hit_cnt + 1'b1;
                            end
                        end else begin
                            hit_cnt_nxt = '0;
                        end
                    end

                    if ((state == COARSE || state == FINE) && state_nxt == state) begin
                        if (tmo_cnt >= TMO_W'(TIMEOUT - 1)) begin
                            state_nxt = FAULT;
                        end else begin
                            tmo_cnt_nxt = tmo_cnt + 1'b1;
                        end
                    end
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (stop_i) begin
            state_nxt   = IDLE;
            rst_cnt_nxt = '0;
            hit_cnt_nxt = '0;
            tmo_cnt_nxt = '0;
            lost_nxt    = 1'b0;
        end
    end

    // Outputs are registered from the next state so they align with state_o.
    always_ff @(posedge fpga_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state          <= IDLE;
            rst_cnt        <= '0;
            hit_cnt        <= '0;
            tmo_cnt        <= '0;
            adpll_enable_o <= 1'b0;
            loop_reset_o   <= 1'b0;
            gain_sel_o     <= 2'b10;
            locked_o       <= 1'b0;
            lock_lost_o    <= 1'b0;
            fault_o        <= 1'b0;
        end else begin
            state          <= state_nxt;
            rst_cnt        <= rst_cnt_nxt;
            hit_cnt        <= hit_cnt_nxt;
            tmo_cnt        <= tmo_cnt_nxt;
            adpll_enable_o <= (state_nxt == COARSE) || (state_nxt == FINE) ||
                              (state_nxt == LOCKED);
            loop_reset_o   <= (state_nxt == LOOP_RST);
            gain_sel_o     <= (state_nxt == FINE)   ? 2'b01 :
                              (state_nxt == LOCKED) ? 2'b00 : 2'b10;
            locked_o       <= (state_nxt == LOCKED);
            lock_lost_o    <= lost_nxt;
            fault_o        <= (state_nxt == FAULT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl with default parameters.
// fpga_clk_i = 100 MHz, reference pulses are 20 clock cycles (5 MHz).
module tb_adpll_lock_ctrl;

    logic              fpga_clk_i = 1'b0;
    logic              reset_ni   = 1'b0;
    logic              start_i    = 1'b0;
    logic              stop_i     = 1'b0;
    logic              ref_clk_i  = 1'b0;
    logic signed [7:0] error_i    = '0;
    logic signed [8:0] dco_cc_i   = '0;
    logic              adpll_enable_o;
    logic              loop_reset_o;
    logic [1:0]        gain_sel_o;
    logic              locked_o;
    logic              lock_lost_o;
    logic              fault_o;
    logic [2:0]        state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int lost_seen = 0;

    adpll_lock_ctrl dut (
        .fpga_clk_i     (fpga_clk_i),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .ref_clk_i      (ref_clk_i),
        .error_i        (error_i),
        .dco_cc_i       (dco_cc_i),
        .adpll_enable_o (adpll_enable_o),
        .loop_reset_o   (loop_reset_o),
        .gain_sel_o     (gain_sel_o),
        .locked_o       (locked_o),
        .lock_lost_o    (lock_lost_o),
        .fault_o        (fault_o),
        .state_o        (state_o)
    );

    always #5 fpga_clk_i = ~fpga_clk_i;

    always @(negedge fpga_clk_i) begin
        if (lock_lost_o === 1'b1) lost_seen = lost_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge fpga_clk_i);
    endtask

    // One reference period; the strobe is acted on well inside it, so
    // outputs are settled when this returns.
    task automatic ref_pulse(input logic signed [7:0] err, input logic signed [8:0] dco);
        error_i   = err;
        dco_cc_i  = dco;
        ref_clk_i = 1'b1;
        cycles(10);
        ref_clk_i = 1'b0;
        cycles(10);
        dco_cc_i  = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"},  32'(state_o), 0);
        check({tag, "_en"},     32'(adpll_enable_o), 0);
        check({tag, "_lrst"},   32'(loop_reset_o), 0);
        check({tag, "_gain"},   32'(gain_sel_o), 2);
        check({tag, "_locked"}, 32'(locked_o), 0);
        check({tag, "_lost"},   32'(lock_lost_o), 0);
        check({tag, "_fault"},  32'(fault_o), 0);
    endtask

    initial begin
        // Reset state
        #12;
        check_idle_outputs("reset");
        @(negedge fpga_clk_i);
        reset_ni = 1'b1;
        cycles(3);
        check("idle_no_start", 32'(state_o), 0);

        // Acquisition: LOOP_RST for 8 cycles
        start_i = 1'b1;
        cycles(1);
        check("lrst_state", 32'(state_o), 1);
        check("lrst_out",   32'(loop_reset_o), 1);
        check("lrst_en",    32'(adpll_enable_o), 0);
        cycles(7);
        check("lrst_8th", 32'(state_o), 1);
        cycles(1);
        check("coarse_state", 32'(state_o), 2);
        check("coarse_en",    32'(adpll_enable_o), 1);
        check("coarse_gain",  32'(gain_sel_o), 2);
        check("coarse_lrst",  32'(loop_reset_o), 0);

        // COARSE: 4 good strobes to FINE
        repeat (3) ref_pulse(8'sd0, 9'sd0);
        check("coarse_3", 32'(state_o), 2);
        ref_pulse(8'sd0, 9'sd0);
        check("fine_state", 32'(state_o), 3);
        check("fine_gain",  32'(gain_sel_o), 1);

        // FINE: 16 good strobes to LOCKED
        repeat (15) ref_pulse(8'sd0, 9'sd0);
        check("fine_15", 32'(state_o), 3);
        check("fine_15_locked", 32'(locked_o), 0);
        ref_pulse(8'sd0, 9'sd0);
        check("locked_state",  32'(state_o), 4);
        check("locked_out",    32'(locked_o), 1);
        check("locked_gain",   32'(gain_sel_o), 0);

        // Three bad strobes then a good one: lock held
        repeat (3) ref_pulse(8'sd20, 9'sd0);
        check("bad3_state", 32'(state_o), 4);
        ref_pulse(8'sd0, 9'sd0);
        check("bad3_good_state", 32'(state_o), 4);
        check("bad3_no_lost",    32'(lost_seen), 0);

        // Four bad strobes: lock lost, single pulse, then COARSE
        repeat (3) ref_pulse(8'sd20, 9'sd0);
        check("bad_pre_state", 32'(state_o), 4);
        ref_pulse(8'sd20, 9'sd0);
        check("lost_state",  32'(state_o), 3);
        check("lost_pulses", 32'(lost_seen), 1);
        check("lost_locked", 32'(locked_o), 0);
        check("lost_gain",   32'(gain_sel_o), 1);
        ref_pulse(8'sd20, 9'sd0);
        check("lost_to_coarse", 32'(state_o), 2);
        check("lost_pulses2",   32'(lost_seen), 1);

        // COARSE: -128 breaks the good run (magnitude 128, not 0)
        repeat (3) ref_pulse(8'sd0, 9'sd0);
        ref_pulse(-8'sd128, 9'sd0);
        check("m128_state", 32'(state_o), 2);
        repeat (3) ref_pulse(8'sd0, 9'sd0);
        check("m128_after3", 32'(state_o), 2);
        // Rail on what would be the 4th good strobe
        ref_pulse(8'sd0, -9'sd256);
        check("rail_n_state", 32'(state_o), 5);
        check("rail_n_fault", 32'(fault_o), 1);
        check("rail_n_en",    32'(adpll_enable_o), 0);
        ref_pulse(8'sd0, 9'sd0);
        check("fault_held", 32'(state_o), 5);

        // stop overrides start
        stop_i = 1'b1;
        cycles(1);
        check("stop_state", 32'(state_o), 0);
        check("stop_fault", 32'(fault_o), 0);
        cycles(5);
        check("stop_start_held", 32'(state_o), 0);
        stop_i = 1'b0;
        cycles(1);
        check("restart_lrst", 32'(state_o), 1);
        cycles(8);
        check("restart_coarse", 32'(state_o), 2);

        // Timeout in FINE with alternating 0/3
        repeat (4) ref_pulse(8'sd0, 9'sd0);
        check("tmo_fine", 32'(state_o), 3);
        for (int i = 0; i < 1023; i++) ref_pulse((i % 2 == 0) ? 8'sd0 : 8'sd3, 9'sd0);
        check("tmo_1023", 32'(state_o), 3);
        ref_pulse(8'sd3, 9'sd0);
        check("tmo_state", 32'(state_o), 5);
        check("tmo_fault", 32'(fault_o), 1);
        check("tmo_en",    32'(adpll_enable_o), 0);

        // Reset during FINE
        stop_i = 1'b1;
        cycles(1);
        stop_i = 1'b0;
        cycles(9);
        check("rst2_coarse", 32'(state_o), 2);
        repeat (4) ref_pulse(8'sd0, 9'sd0);
        repeat (5) ref_pulse(8'sd0, 9'sd0);
        check("rst2_fine", 32'(state_o), 3);
        start_i  = 1'b0;
        reset_ni = 1'b0;
        #1;
        check_idle_outputs("midrst");
        cycles(2);
        reset_ni = 1'b1;
        cycles(3);
        check("midrst_idle", 32'(state_o), 0);

        // New sequence: progress was discarded, and +255 rails in FINE
        start_i = 1'b1;
        cycles(9);
        check("seq3_coarse", 32'(state_o), 2);
        repeat (4) ref_pulse(8'sd0, 9'sd0);
        repeat (15) ref_pulse(8'sd0, 9'sd0);
        check("seq3_fine15", 32'(state_o), 3);
        ref_pulse(8'sd0, 9'sd255);
        check("rail_p_state", 32'(state_o), 5);
        check("rail_p_fault", 32'(fault_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adpll_lock_ctrl.md
ADPLL_LOCK_CTRL -- requirements
Module: adpll_lock_ctrl

Interface
REQ-001 SHALL have parameter LOCK_TOL, default 2, max |error| counted as in-lock.
REQ-002 SHALL have parameter LOCK_CNT, default 16, consecutive in-lock samples needed to declare lock.
REQ-003 SHALL have parameter COARSE_TOL, default 16, max |error| for coarse-to-fine handover.
REQ-004 SHALL have parameter UNLOCK_TOL, default 8, |error| above which a locked sample counts as bad.
REQ-005 SHALL have parameter UNLOCK_CNT, default 4, consecutive bad samples that drop lock.
REQ-006 SHALL have parameter TIMEOUT, default 1024, ref samples allowed in COARSE or FINE before fault.
REQ-007 SHALL have parameter RST_CYCLES, default 8, fpga_clk_i cycles of loop reset.
REQ-008 SHALL have port fpga_clk_i input 1, the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset_ni input 1, asynchronous active-low reset.
REQ-010 SHALL have port start_i input 1, level request to acquire lock.
REQ-011 SHALL have port stop_i input 1, level request to abort and return to IDLE.
REQ-012 SHALL have port ref_clk_i input 1, reference clock, asynchronous to fpga_clk_i.
REQ-013 SHALL have port error_i input 8 signed, phase error from the ADPLL phase detector.
REQ-014 SHALL have port dco_cc_i input 9 signed, DCO control code from the ADPLL.
REQ-015 SHALL have port adpll_enable_o output 1, drives ADPLL enable_i.
REQ-016 SHALL have port loop_reset_o output 1, active-high reset to the ADPLL loop.
REQ-017 SHALL have port gain_sel_o output 2, loop filter gain: 10 coarse, 01 fine, 00 tracking.
REQ-018 SHALL have port locked_o output 1, high in LOCKED only.
REQ-019 SHALL have port lock_lost_o output 1, one-cycle pulse on LOCKED exit due to bad samples.
REQ-020 SHALL have port fault_o output 1, high in FAULT only.
REQ-021 SHALL have port state_o output 3, current state encoding.

Function
REQ-022 SHALL synchronise ref_clk_i through two flops and form a one-cycle strobe on its rising edge; error_i is sampled only on strobe cycles.
REQ-023 SHALL compute |error_i| as 8-bit unsigned magnitude with -128 mapping to 128 (no wrap to 0 or negative).
REQ-024 SHALL implement states IDLE=0, LOOP_RST=1, COARSE=2, FINE=3, LOCKED=4, FAULT=5 on state_o.
REQ-025 IDLE: adpll_enable_o=0, loop_reset_o=0, gain_sel_o=10; start_i=1 and stop_i=0 -> LOOP_RST.
REQ-026 LOOP_RST: loop_reset_o=1, adpll_enable_o=0 for exactly RST_CYCLES cycles, then -> COARSE.
REQ-027 COARSE: adpll_enable_o=1, gain_sel_o=10; 4 consecutive strobes with |error|<=COARSE_TOL -> FINE; a failing strobe clears the count.
REQ-028 FINE: gain_sel_o=01; LOCK_CNT consecutive strobes with |error|<=LOCK_TOL -> LOCKED; any strobe with |error|>COARSE_TOL -> COARSE.
REQ-029 LOCKED: gain_sel_o=00, locked_o=1; UNLOCK_CNT consecutive strobes with |error|>UNLOCK_TOL -> FINE with lock_lost_o=1 for that transition cycle; a good strobe clears the count.
REQ-030 Timeout counter SHALL clear on entry to COARSE and FINE, count strobes there, and at TIMEOUT -> FAULT.
REQ-031 In COARSE, FINE or LOCKED, dco_cc_i equal to +255 or -256 on a strobe -> FAULT (rail takes priority over all tolerance tests that strobe).
REQ-032 FAULT: adpll_enable_o=0, fault_o=1; left only via stop_i.
REQ-033 stop_i=1 SHALL force IDLE on the next edge from any state, overriding all other transitions including same-cycle start_i.
REQ-034 All outputs SHALL be registered; state change is visible one cycle after the deciding strobe.
REQ-035 Counters SHALL saturate, never wrap.

Reset
REQ-036 reset_ni=0 SHALL immediately force IDLE, all counters 0, synchroniser flops 0, adpll_enable_o=0, loop_reset_o=0, gain_sel_o=10, locked_o=0, lock_lost_o=0, fault_o=0, state_o=0.
REQ-037 Reset asserted mid-acquisition SHALL discard all progress; release requires start_i for a new sequence.

Verification
REQ-038 start_i=1, error_i=0 constant, 5 MHz ref -> LOOP_RST 8 cycles, COARSE 4 strobes, FINE 16 strobes, locked_o=1, gain_sel_o=00.
REQ-039 Locked, error_i=+20 for 4 strobes -> lock_lost_o single pulse, state FINE then COARSE on next strobe.
REQ-040 Locked, error_i=+20 for 3 strobes then 0 -> stays LOCKED, no lock_lost_o.
REQ-041 In FINE, error_i alternates 0/3 -> never locks; after 1024 strobes fault_o=1, adpll_enable_o=0.
REQ-042 In COARSE, error_i=-128 -> magnitude 128, no progress; dco_cc_i=-256 -> FAULT; stop_i -> IDLE; start_i and stop_i both high -> IDLE held.
REQ-043 reset_ni pulsed low during FINE -> all outputs at reset values immediately, IDLE after release.
